// File: rtl/mantissa_seq_mult.sv
// Sequential shift-add significand multiplier: one multiplier bit per cycle,
// producing the full 2*MW-bit unsigned product for the FP normalize stage.
module mantissa_seq_mult #(
  parameter int MW = 24,
  parameter int CW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MW-2:0]     mant_a,
  input  logic [MW-2:0]     mant_b,
  input  logic              hid_a,
  input  logic              hid_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*MW-1:0]   prdt,
  output logic              norm_hint
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [MW-1:0]     mcand_q;
  logic [MW-1:0]     mplr_q;
  logic [MW-1:0]     acc_hi_q;
  logic [MW-1:0]     acc_lo_q;
  logic [CW-1:0]     count_q;
  logic [2*MW-1:0]   prdt_q;
  logic              norm_hint_q;

  logic [MW-1:0]     op_a;
  logic [MW-1:0]     op_b;
  logic              op_zero;
  logic [MW:0]       sum_d;
  logic              last_step;

  assign op_a    = {hid_a, mant_a};
  assign op_b    = {hid_b, mant_b};
  assign op_zero = (op_a == '0) || (op_b == '0);

  // Partial sum keeps the carry so the top product bit is never lost.
  assign sum_d     = {1'b0, acc_hi_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(MW+1){1'b0}});
  assign last_step = (count_q == CW'(MW - 1));

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign prdt      = prdt_q;
  assign norm_hint = norm_hint_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the datapath registers are reset too so an aborted
  // operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      count_q     <= '0;
      prdt_q      <= '0;
      norm_hint_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_q  <= op_a;
            mplr_q   <= op_b;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
            if (op_zero) begin
              prdt_q      <= '0;
              norm_hint_q <= 1'b0;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          // Shift {sum, acc_lo} right by one: low sum bit enters acc_lo.
          acc_hi_q <= sum_d[MW:1];
          acc_lo_q <= {sum_d[0], acc_lo_q[MW-1:1]};
          mplr_q   <= mplr_q >> 1;
          count_q  <= count_q + CW'(1);
          if (last_step) begin
            prdt_q      <= {sum_d, acc_lo_q[MW-1:1]};
            norm_hint_q <= sum_d[MW];
            state_q     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
